// File: rtl/isp_tpg_source_if.sv
// Pixel-stream bundle between a video source and an ISP stage:
// frame/line syncs, data-enable and 8-bit R/G/B.
interface isp_tpg_source_if;
  logic       vsync;
  logic       hsync;
  logic       den;
  logic [7:0] data_r;
  logic [7:0] data_g;
  logic [7:0] data_b;

  modport master (output vsync, hsync, den, data_r, data_g, data_b);
  modport slave  (input  vsync, hsync, den, data_r, data_g, data_b);
endinterface

// File: rtl/isp_tpg_source.sv
// Test-pattern video source. Generates raster timing and one of four patterns
// (colour bars, gradient, flat grey, checkerboard), then applies per-channel
// Q1.7 colour-cast gains with saturation. Two-stage output pipeline.
// Optional macro TPG_BORDER_EN: forces a one-pixel white border before the gain.
module isp_tpg_source #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned H_BLANK  = 64,
  parameter int unsigned V_BLANK  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  input  logic [7:0]              cast_R,
  input  logic [7:0]              cast_G,
  input  logic [7:0]              cast_B,
  isp_tpg_source_if.master        pix,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] SUB_LAST   = BW'(BAR_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          start;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap, frame_end;
  logic          vsync_i, hsync_i;

  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_sub;

  logic [1:0]    cfg_pat;
  logic [7:0]    cfg_r, cfg_g, cfg_b;

  logic          x5, y5;
  logic [7:0]    pat_r, pat_g, pat_b;

  logic          vs1, hs1, vs2, hs2;
  logic [7:0]    p1_r, p1_g, p1_b;
  logic [7:0]    d2_r, d2_g, d2_b;

  // (p * c) >> 7, clamped to 255; bit 8 of the shifted product flags overflow
  function automatic logic [7:0] apply_gain(input logic [7:0] p, input logic [7:0] c);
    logic [8:0] scaled;
    scaled = 9'(({8'd0, p} * {8'd0, c}) >> 7);
    return scaled[8] ? 8'hFF : scaled[7:0];
  endfunction

  assign h_wrap    = (h == H_LAST);
  assign frame_end = (state_q == VBLANK) && h_wrap && (v == V_LAST);
  assign vsync_i   = (state_q == ACTIVE);
  assign hsync_i   = vsync_i && (h < H_ACT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state; start marks a frame beginning at h=v=0
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (h_wrap && (v == V_ACT_LAST)) state_d = VBLANK;
      end
      VBLANK: begin
        if (frame_end) begin
          if (enable) begin
            state_d = ACTIVE;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster counters; held at zero while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (state_q == IDLE) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Bar index/sub-counter track h across the active part of each line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_idx <= '0;
      bar_sub <= '0;
    end else if (!hsync_i) begin
      bar_idx <= '0;
      bar_sub <= '0;
    end else if (bar_sub == SUB_LAST) begin
      bar_sub <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_sub <= bar_sub + BW'(1);
    end
  end

  // Pattern and gains are captured only as a frame starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_pat <= '0;
      cfg_r   <= '0;
      cfg_g   <= '0;
      cfg_b   <= '0;
    end else if (start) begin
      cfg_pat <= pattern_sel;
      cfg_r   <= cast_R;
      cfg_g   <= cast_G;
      cfg_b   <= cast_B;
    end
  end

  // Completed-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 16'd1;
  end

  // Bit 5 of x/y; a counter narrower than 6 bits never sets it
  assign x5 = |(h & HW'(32));
  assign y5 = |(v & VW'(32));

  // Pattern pixel for the current raster position
  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (cfg_pat)
      2'd0: begin
        pat_r = {8{~bar_idx[1]}};
        pat_g = {8{~bar_idx[2]}};
        pat_b = {8{~bar_idx[0]}};
      end
      2'd1: begin
        pat_r = 8'(h);
        pat_g = 8'(h);
        pat_b = 8'(h);
      end
      2'd2: begin
        pat_r = 8'd128;
        pat_g = 8'd128;
        pat_b = 8'd128;
      end
      default: begin
        pat_r = {8{x5 ^ y5}};
        pat_g = {8{x5 ^ y5}};
        pat_b = {8{x5 ^ y5}};
      end
    endcase
`ifdef TPG_BORDER_EN
    if ((h == '0) || (h == H_ACT_LAST) || (v == '0) || (v == V_ACT_LAST)) begin
      pat_r = '1;
      pat_g = '1;
      pat_b = '1;
    end
`endif
  end

  // Stage 1: register pattern pixel and syncs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs1  <= 1'b0;
      hs1  <= 1'b0;
      p1_r <= '0;
      p1_g <= '0;
      p1_b <= '0;
    end else begin
      vs1  <= vsync_i;
      hs1  <= hsync_i;
      p1_r <= hsync_i ? pat_r : '0;
      p1_g <= hsync_i ? pat_g : '0;
      p1_b <= hsync_i ? pat_b : '0;
    end
  end

  // Stage 2: gain/saturate, data forced to zero outside den
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs2  <= 1'b0;
      hs2  <= 1'b0;
      d2_r <= '0;
      d2_g <= '0;
      d2_b <= '0;
    end else begin
      vs2  <= vs1;
      hs2  <= hs1;
      d2_r <= hs1 ? apply_gain(p1_r, cfg_r) : '0;
      d2_g <= hs1 ? apply_gain(p1_g, cfg_g) : '0;
      d2_b <= hs1 ? apply_gain(p1_b, cfg_b) : '0;
    end
  end

  assign pix.vsync  = vs2;
  assign pix.hsync  = hs2;
  assign pix.den    = hs2;
  assign pix.data_r = d2_r;
  assign pix.data_g = d2_g;
  assign pix.data_b = d2_b;

endmodule

// File: tb/tb_isp_tpg_source.sv
// Self-checking bench for isp_tpg_source on a small 16x4 raster.
// A frame-position reference model predicts every output cycle.
module tb_isp_tpg_source;

  localparam int unsigned HA = 16;
  localparam int unsigned HB = 4;
  localparam int unsigned VA = 4;
  localparam int unsigned VB = 2;
  localparam int unsigned HT = HA + HB;
  localparam int unsigned FT = HT * (VA + VB);
  localparam int          LIM = 400;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       den;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [7:0]  cast_R, cast_G, cast_B;
  logic [15:0] frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  isp_tpg_source_if pix ();

  isp_tpg_source #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .H_BLANK (HB),
    .V_BLANK (VB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .cast_R     (cast_R),
    .cast_G     (cast_G),
    .cast_B     (cast_B),
    .pix        (pix),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [7:0] gain(input int p, input int c);
    int s;
    s = (p * c) >> 7;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // Expected port values for raster position pos of a running frame
  function automatic px_t ref_px(input bit run, input int pos, input int pat,
                                 input int cr, input int cg, input int cb);
    px_t o;
    int x, y, r, g, b;
    logic [23:0] c;
    o = '0;
    if (!run) return o;
    x = pos % HT;
    y = pos / HT;
    o.vs  = (y < VA);
    o.hs  = o.vs && (x < HA);
    o.den = o.hs;
    if (!o.den) return o;
    case (pat)
      0: begin
        c = bars[x / (HA / 8)];
        r = int'(c[23:16]); g = int'(c[15:8]); b = int'(c[7:0]);
      end
      1: begin r = x % 256; g = r; b = r; end
      2: begin r = 128; g = 128; b = 128; end
      default: begin
        r = (((x / 32) % 2) != ((y / 32) % 2)) ? 255 : 0;
        g = r; b = r;
      end
    endcase
`ifdef TPG_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) begin
      r = 255; g = 255; b = 255;
    end
`endif
    o.r = gain(r, cr);
    o.g = gain(g, cg);
    o.b = gain(b, cb);
    return o;
  endfunction

  // Reference model: frame position plus a two-deep output delay
  bit          m_run;
  int          m_pos, m_pat, m_cr, m_cg, m_cb;
  px_t         m_s1, m_s2;
  logic [15:0] m_fcnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 1'b0; m_pos <= 0; m_fcnt <= '0;
      m_s1 <= '0; m_s2 <= '0;
      m_pat <= 0; m_cr <= 0; m_cg <= 0; m_cb <= 0;
    end else begin
      m_s1 <= ref_px(m_run, m_pos, m_pat, m_cr, m_cg, m_cb);
      m_s2 <= m_s1;
      if (!m_run) begin
        if (enable) begin
          m_run <= 1'b1; m_pos <= 0;
          m_pat <= int'(pattern_sel); m_cr <= int'(cast_R); m_cg <= int'(cast_G); m_cb <= int'(cast_B);
        end
      end else if (m_pos == FT - 1) begin
        m_fcnt <= m_fcnt + 16'd1;
        m_pos  <= 0;
        if (enable) begin
          m_pat <= int'(pattern_sel); m_cr <= int'(cast_R); m_cg <= int'(cast_G); m_cb <= int'(cast_B);
        end else begin
          m_run <= 1'b0;
        end
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic [42:0] dut_vec();
    return {pix.vsync, pix.hsync, pix.den, pix.data_r, pix.data_g, pix.data_b, frame_cnt};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One clock; sample on the falling edge and compare with the model
  task automatic tick();
    @(negedge clk);
    chk("stream", 64'(dut_vec()), 64'({m_s2, m_fcnt}));
  endtask

  task automatic wait_frame_start();
    int  n;
    logic prev;
    n = 0;
    prev = pix.vsync;
    while (n < LIM) begin
      tick();
      n++;
      if (pix.vsync && !prev) break;
      prev = pix.vsync;
    end
    n_total++;
    assert (n < LIM) n_pass++;
    else $error("FAIL frame_start_timeout got=%0d exp=<%0d", n, LIM);
  endtask

  task automatic den_latency(input string tag);
    int n;
    n = 0;
    while (!pix.den && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'd3);
  endtask

  initial begin
    int hi, lo, dh;
    reset_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    cast_R = 8'd128; cast_G = 8'd128; cast_B = 8'd128;

    repeat (3) tick();
    chk("reset_zero", 64'(dut_vec()), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // One edge to leave IDLE plus two pipeline stages
    enable = 1'b1;
    den_latency("first_den_latency");

    hi = 0; dh = 0;
    while (pix.vsync && hi < LIM) begin
      hi++;
      if (pix.den) dh++;
      tick();
    end
    lo = 0;
    while (!pix.vsync && lo < LIM) begin
      lo++;
      tick();
    end
    chk("vsync_high", 64'(hi), 64'd80);
    chk("den_high",   64'(dh), 64'd64);
    chk("vsync_low",  64'(lo), 64'd40);
    chk("fcnt_first", 64'(frame_cnt), 64'd1);

    for (int unsigned i = 0; i < HA; i++) begin
      chk($sformatf("bar%0d", i), 64'({pix.data_r, pix.data_g, pix.data_b}), 64'(bars[i / 2]));
      tick();
    end

    pattern_sel = 2'd2;
    cast_R = 8'd192; cast_G = 8'd128; cast_B = 8'd64;
    wait_frame_start();
    chk("gain_grey", 64'({pix.data_r, pix.data_g, pix.data_b}), 64'h00C08040);

    cast_R = 8'd255;
    wait_frame_start();
    chk("gain_r255", 64'(pix.data_r), 64'd255);

    pattern_sel = 2'd0;
    cast_B = 8'd128;
    wait_frame_start();
    chk("white_sat", 64'({pix.data_r, pix.data_g, pix.data_b}), 64'h00FFFFFF);

    cast_R = 8'd128; cast_G = 8'd128; cast_B = 8'd128;
    pattern_sel = 2'd2;
    wait_frame_start();
    repeat (30) tick();
    pattern_sel = 2'd3;
    repeat (11) tick();
    chk("latch_hold", 64'({pix.den, pix.data_r, pix.data_g, pix.data_b}), 64'h1808080);
    wait_frame_start();
    chk("latch_next", 64'({pix.den, pix.data_r, pix.data_g, pix.data_b}), 64'h1000000);

    // Drop enable on the second line; the frame must still run to completion
    wait_frame_start();
    repeat (25) tick();
    enable = 1'b0;
    hi = 0;
    while (pix.vsync && hi < LIM) begin
      hi++;
      tick();
    end
    chk("drop_rest_active", 64'(hi), 64'd55);
    repeat (60) tick();
    chk("drop_idle", 64'({pix.vsync, pix.den, pix.data_r, pix.data_g, pix.data_b}), 64'd0);
    enable = 1'b1;
    den_latency("restart_latency");

    // Counters reach v=2,h=5 two clocks ahead of the visible pixel
    repeat (43) tick();
    reset_n = 1'b0;
    #1;
    chk("reset_mid", 64'(dut_vec()), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    wait_frame_start();
    hi = 0;
    while (pix.vsync && hi < LIM) begin
      hi++;
      tick();
    end
    chk("restart_active", 64'(hi), 64'd80);

    for (int unsigned f = 0; f < 10; f++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      cast_R = 8'($urandom_range(0, 255));
      cast_G = 8'($urandom_range(0, 255));
      cast_B = 8'($urandom_range(0, 255));
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(20, 150)) tick();
    end
    enable = 1'b0;
    repeat (2 * FT + 10) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
